// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: pops the FIFO, captures read data into a 2-entry skid buffer
// and forwards it downstream under pausa_in backpressure. FIFO_DRAIN_COUNT_EN adds rd_count.
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH    = 6,
  parameter int SKID_DEPTH    = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  empty_in,
  input  logic                  almost_empty_in,
  input  logic                  fifo_error_in,
  input  logic                  pausa_in,
  output logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  err_out,
  output logic [7:0]            rd_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_POP    = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam int         CNT_W     = $clog2(SETTLE_CYCLES + 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pop_q;
  logic                  inflight_q;
  logic [1:0]            occ_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] skid_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  err_q;

  logic                  out_fire;
  logic [1:0]            occ_after;
  logic [2:0]            owed;
  logic                  credit;

  // Every word already requested (pop this cycle, in flight, or buffered) owns a skid slot,
  // so a sudden pause can never overflow the buffer.
  assign out_fire  = !pausa_in && (occ_q != 2'd0);
  assign occ_after = occ_q - {1'b0, out_fire};
  assign owed      = {1'b0, occ_after} + {2'b00, inflight_q} + {2'b00, pop_q};
  assign credit    = owed < 3'(SKID_DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty_in && credit) state_d = ST_POP;
      end
      ST_POP: begin
        if (almost_empty_in) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
        end else if (!empty_in && credit) begin
          state_d = ST_POP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data arrives the cycle after pop, so it is captured one cycle behind the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pop_q      <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_q[i] <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pop_q      <= (state_d == ST_POP);
      inflight_q <= pop_q;
      err_q      <= err_q | fifo_error_in | (pop_q & empty_in);
      if (inflight_q) begin
        skid_q[wr_ptr_q] <= fifo_data_in;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (out_fire) begin
        data_q   <= skid_q[rd_ptr_q];
        rd_ptr_q <= ~rd_ptr_q;
      end
      valid_q <= out_fire;
      occ_q   <= occ_q + {1'b0, inflight_q} - {1'b0, out_fire};
    end
  end

  assign pop       = pop_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign err_out   = err_q;

`ifdef FIFO_DRAIN_COUNT_EN
  logic [7:0] count_q;

  // Counts words as they are presented; holds at 255 rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else if (out_fire && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign rd_count = count_q;
`else
  assign rd_count = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural FIFO model on the read port.
// Expected rd_count values follow FIFO_DRAIN_COUNT_EN.
module tb_fifo_drain_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] fifo_data_in;
  logic       empty_in;
  logic       almost_empty_in;
  logic       fifo_error_in;
  logic       pausa_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       err_out;
  logic [7:0] rd_count;

  int         testsRun = 0;
  int         testsFailed = 0;

  logic [5:0] fifoQ[$];
  logic [5:0] rxQ[$];
  int         popCount;
  int         cycleNum;
  int         firstPopCycle;
  int         firstValidCycle;
  logic       lastPop;
  logic [7:0] lastRdCount;

  fifo_drain_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_data_in   (fifo_data_in),
    .empty_in       (empty_in),
    .almost_empty_in(almost_empty_in),
    .fifo_error_in  (fifo_error_in),
    .pausa_in       (pausa_in),
    .pop            (pop),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .err_out        (err_out),
    .rd_count       (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic updateFlags();
    empty_in        = (fifoQ.size() == 0);
    almost_empty_in = (fifoQ.size() == 1);
  endtask

  task automatic applyStimulus(input logic [5:0] word);
    fifoQ.push_back(word);
    updateFlags();
  endtask

  task automatic clearLog();
    rxQ.delete();
    popCount        = 0;
    cycleNum        = 0;
    firstPopCycle   = -1;
    firstValidCycle = -1;
    lastPop         = 1'b0;
  endtask

  // Observe outputs mid-cycle, then let the FIFO model answer any pop just after the edge.
  task automatic stepCycle();
    @(negedge clk);
    lastPop     = pop;
    lastRdCount = rd_count;
    if (pop) begin
      popCount++;
      if (firstPopCycle < 0) firstPopCycle = cycleNum;
    end
    if (valid_out) begin
      rxQ.push_back(data_out);
      if (firstValidCycle < 0) firstValidCycle = cycleNum;
    end
    @(posedge clk);
    #1;
    if (lastPop && (fifoQ.size() > 0)) fifo_data_in = fifoQ.pop_front();
    updateFlags();
    cycleNum++;
  endtask

  task automatic doReset();
    reset = 1'b1;
    fifoQ.delete();
    fifo_data_in  = '0;
    fifo_error_in = 1'b0;
    updateFlags();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic       found;
    logic       midDone;
    int         guard;
    int         orderErrs;
    logic [7:0] expCount;

    reset         = 1'b1;
    fifo_data_in  = '0;
    fifo_error_in = 1'b0;
    pausa_in      = 1'b0;
    updateFlags();
    clearLog();

    #12;
    checkOutput("rst_pop",      {31'd0, pop},       32'd0);
    checkOutput("rst_valid",    {31'd0, valid_out}, 32'd0);
    checkOutput("rst_data",     {26'd0, data_out},  32'd0);
    checkOutput("rst_err",      {31'd0, err_out},   32'd0);
    checkOutput("rst_rd_count", {24'd0, rd_count},  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Streaming three words
    clearLog();
    applyStimulus(6'h01);
    applyStimulus(6'h02);
    applyStimulus(6'h03);
    repeat (15) stepCycle();
    checkOutput("stream_count", rxQ.size(), 3);
    if (rxQ.size() == 3) begin
      checkOutput("stream_w0", {26'd0, rxQ[0]}, 32'h01);
      checkOutput("stream_w1", {26'd0, rxQ[1]}, 32'h02);
      checkOutput("stream_w2", {26'd0, rxQ[2]}, 32'h03);
    end
    checkOutput("stream_latency", firstValidCycle - firstPopCycle, 3);
    checkOutput("stream_pops", popCount, 3);
    checkOutput("stream_err", {31'd0, err_out}, 32'd0);

    // Asynchronous reset while popping
    applyStimulus(6'h31);
    applyStimulus(6'h32);
    applyStimulus(6'h33);
    applyStimulus(6'h34);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (pop) found = 1'b1;
    end
    checkOutput("midrst_pop_seen", {31'd0, found}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_pop",      {31'd0, pop},       32'd0);
    checkOutput("midrst_valid",    {31'd0, valid_out}, 32'd0);
    checkOutput("midrst_data",     {26'd0, data_out},  32'd0);
    checkOutput("midrst_err",      {31'd0, err_out},   32'd0);
    checkOutput("midrst_rd_count", {24'd0, rd_count},  32'd0);
    fifoQ.delete();
    updateFlags();
    @(negedge clk);
    reset = 1'b0;
    clearLog();
    repeat (8) stepCycle();
    checkOutput("midrst_discard", rxQ.size(), 0);

    // Backpressure: only two words may be requested while paused
    clearLog();
    pausa_in = 1'b1;
    applyStimulus(6'h10);
    applyStimulus(6'h11);
    applyStimulus(6'h12);
    applyStimulus(6'h13);
    repeat (12) stepCycle();
    checkOutput("pause_pops",  popCount,    2);
    checkOutput("pause_valid", rxQ.size(),  0);
    pausa_in = 1'b0;
    repeat (30) stepCycle();
    checkOutput("pause_count", rxQ.size(), 4);
    if (rxQ.size() == 4) begin
      for (int i = 0; i < 4; i++) checkOutput("pause_word", {26'd0, rxQ[i]}, 32'h10 + i);
    end
    checkOutput("pause_err", {31'd0, err_out}, 32'd0);

    // Almost-empty settle gap, even though the FIFO refills immediately
    clearLog();
    applyStimulus(6'h21);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      stepCycle();
      if (lastPop) found = 1'b1;
    end
    checkOutput("settle_first_pop", {31'd0, found}, 32'd1);
    applyStimulus(6'h22);
    applyStimulus(6'h23);
    applyStimulus(6'h24);
    stepCycle();
    checkOutput("settle_gap1", {31'd0, lastPop}, 32'd0);
    stepCycle();
    checkOutput("settle_gap2", {31'd0, lastPop}, 32'd0);
    stepCycle();
    checkOutput("settle_idle", {31'd0, lastPop}, 32'd0);
    stepCycle();
    checkOutput("settle_resume", {31'd0, lastPop}, 32'd1);
    repeat (30) stepCycle();
    checkOutput("settle_count", rxQ.size(), 4);
    if (rxQ.size() == 4) begin
      for (int i = 0; i < 4; i++) checkOutput("settle_word", {26'd0, rxQ[i]}, 32'h21 + i);
    end

    // Sticky error from a one-cycle fifo_error_in pulse
    checkOutput("err_pre", {31'd0, err_out}, 32'd0);
    fifo_error_in = 1'b1;
    stepCycle();
    fifo_error_in = 1'b0;
    checkOutput("err_set", {31'd0, err_out}, 32'd1);
    repeat (5) stepCycle();
    checkOutput("err_hold", {31'd0, err_out}, 32'd1);
    doReset();
    checkOutput("err_cleared", {31'd0, err_out}, 32'd0);

    // Pop seen while the FIFO reports empty also sets the error
    applyStimulus(6'h05);
    applyStimulus(6'h06);
    applyStimulus(6'h07);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (pop) found = 1'b1;
    end
    empty_in = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("err_pop_empty", {31'd0, err_out & found}, 32'd1);
    doReset();

    // Long run to exercise rd_count saturation
    clearLog();
    for (int i = 0; i < 260; i++) applyStimulus(6'(i));
    midDone = 1'b0;
    guard   = 0;
    while (rxQ.size() < 260 && guard < 3000) begin
      stepCycle();
      guard++;
      if (!midDone && rxQ.size() >= 100) begin
        midDone = 1'b1;
`ifdef FIFO_DRAIN_COUNT_EN
        expCount = 8'(rxQ.size());
`else
        expCount = 8'd0;
`endif
        checkOutput("rd_count_mid", {24'd0, lastRdCount}, {24'd0, expCount});
      end
    end
    checkOutput("count_words", rxQ.size(), 260);
    orderErrs = 0;
    for (int i = 0; i < rxQ.size(); i++) begin
      if (rxQ[i] !== 6'(i)) orderErrs++;
    end
    checkOutput("count_order", orderErrs, 0);
`ifdef FIFO_DRAIN_COUNT_EN
    expCount = 8'd255;
`else
    expCount = 8'd0;
`endif
    checkOutput("rd_count_final", {24'd0, lastRdCount}, {24'd0, expCount});
    checkOutput("count_err", {31'd0, err_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
